// File: rtl/gc_dram_pkg.sv
// rtl/gc_dram_pkg.sv - shared types, default sizes and address-split helpers for the gain-cell DRAM controller
package gc_dram_pkg;

   localparam int DEF_NUM_BANKS    = 8;
   localparam int DEF_ROWS         = 128;
   localparam int DEF_WIDTH        = 64;
   localparam int DEF_REF_INTERVAL = 64;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_REF_RD = 2'd1,
      ST_REF_WR = 2'd2
   } state_e;

   // Flat address layout is {bank, row}; callers truncate the result to their field width.
   function automatic int unsigned bank_of(input logic [31:0] addr, input int unsigned row_w);
      return int'(addr >> row_w);
   endfunction

   function automatic int unsigned row_of(input logic [31:0] addr, input int unsigned row_w);
      return int'(addr & ((32'd1 << row_w) - 32'd1));
   endfunction

endpackage

// File: rtl/gc_dram_refresh_timer.sv
// rtl/gc_dram_refresh_timer.sv - refresh interval counter, pending flag and row pointer
module gc_dram_refresh_timer
   import gc_dram_pkg::*;
#(
   parameter int  ROWS         = DEF_ROWS,
   parameter int  REF_INTERVAL = DEF_REF_INTERVAL,
   localparam int ROW_W        = $clog2(ROWS)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ref_ack,
   input  logic             row_inc,
   output logic             ref_tick,
   output logic             ref_pending,
   output logic [ROW_W-1:0] ref_row
);

   localparam int CNT_W = $clog2(REF_INTERVAL);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pending_q, pending_d;
   logic [ROW_W-1:0] row_q, row_d;

   assign ref_tick    = (cnt_q == CNT_W'(REF_INTERVAL - 1));
   assign ref_pending = pending_q;
   assign ref_row     = row_q;

   // A tick seen while the controller is idle is consumed on the same edge, so the
   // flag only persists when the controller cannot start a refresh straight away.
   always_comb begin
      cnt_d     = ref_tick ? '0 : cnt_q + CNT_W'(1);
      pending_d = (pending_q | ref_tick) & ~ref_ack;
      row_d     = row_inc ? row_q + ROW_W'(1) : row_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q     <= '0;
         pending_q <= 1'b0;
         row_q     <= '0;
      end else begin
         cnt_q     <= cnt_d;
         pending_q <= pending_d;
         row_q     <= row_d;
      end
   end

endmodule

// File: rtl/gc_dram_refresh_ctrl.sv
// rtl/gc_dram_refresh_ctrl.sv - banked gain-cell DRAM controller: address decode, 2-cycle reads with bypass, row refresh
module gc_dram_refresh_ctrl
   import gc_dram_pkg::*;
#(
   parameter int  NUM_BANKS    = DEF_NUM_BANKS,
   parameter int  ROWS         = DEF_ROWS,
   parameter int  WIDTH        = DEF_WIDTH,
   parameter int  REF_INTERVAL = DEF_REF_INTERVAL,
   localparam int BANK_W       = $clog2(NUM_BANKS),
   localparam int ROW_W        = $clog2(ROWS),
   localparam int ADDR_W       = BANK_W + ROW_W
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we,
   input  logic                       re,
   input  logic [ADDR_W-1:0]          waddr,
   input  logic [ADDR_W-1:0]          raddr,
   input  logic [WIDTH-1:0]           in,
   output logic                       ready,
   output logic [WIDTH-1:0]           rd,
   output logic                       rd_valid,
   output logic                       ref_busy,
   output logic [NUM_BANKS-1:0]       mem_we,
   output logic [NUM_BANKS-1:0]       mem_re,
   output logic [ROW_W-1:0]           mem_waddr,
   output logic [ROW_W-1:0]           mem_raddr,
   output logic [NUM_BANKS*WIDTH-1:0] mem_wdata,
   input  logic [NUM_BANKS*WIDTH-1:0] mem_rd
);

   state_e             state_q, state_d;
   logic               ref_busy_q, ref_busy_d;
   logic               s1_q, s1_d;
   logic [BANK_W-1:0]  bank_q, bank_d;
   logic               byp_q, byp_d;
   logic [WIDTH-1:0]   byp_data_q, byp_data_d;
   logic [WIDTH-1:0]   rd_q, rd_d;
   logic               rd_valid_q, rd_valid_d;

   logic               ref_tick, ref_pending, ref_ack, row_inc;
   logic [ROW_W-1:0]   ref_row;
   logic [BANK_W-1:0]  wbank, rbank;
   logic [ROW_W-1:0]   wrow, rrow;
   logic               acc_w, acc_r;
   logic [WIDTH-1:0]   bank_rd [NUM_BANKS];

   gc_dram_refresh_timer #(
      .ROWS         (ROWS),
      .REF_INTERVAL (REF_INTERVAL)
   ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .ref_ack     (ref_ack),
      .row_inc     (row_inc),
      .ref_tick    (ref_tick),
      .ref_pending (ref_pending),
      .ref_row     (ref_row)
   );

   assign wbank = BANK_W'(bank_of(32'(waddr), ROW_W));
   assign rbank = BANK_W'(bank_of(32'(raddr), ROW_W));
   assign wrow  = ROW_W'(row_of(32'(waddr), ROW_W));
   assign rrow  = ROW_W'(row_of(32'(raddr), ROW_W));

   assign ready = (state_q == ST_IDLE) && !ref_pending && !rst;
   assign acc_w = ready && we;
   assign acc_r = ready && re;

   assign rd       = rd_q;
   assign rd_valid = rd_valid_q;
   assign ref_busy = ref_busy_q;

   always_comb begin
      for (int b = 0; b < NUM_BANKS; b++) begin
         bank_rd[b] = mem_rd[b*WIDTH +: WIDTH];
      end
   end

   always_comb begin
      state_d    = state_q;
      ref_busy_d = ref_busy_q;
      ref_ack    = 1'b0;
      row_inc    = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (ref_pending || ref_tick) begin
               state_d    = ST_REF_RD;
               ref_busy_d = 1'b1;
               ref_ack    = 1'b1;
            end
         end
         ST_REF_RD: state_d = ST_REF_WR;
         ST_REF_WR: begin
            state_d    = ST_IDLE;
            ref_busy_d = 1'b0;
            row_inc    = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Refresh write-back takes each bank's own read data from the previous cycle.
   always_comb begin
      mem_we    = '0;
      mem_re    = '0;
      mem_waddr = wrow;
      mem_raddr = rrow;
      if (state_q == ST_REF_RD) begin
         mem_re    = '1;
         mem_raddr = ref_row;
      end else if (state_q == ST_REF_WR) begin
         mem_we    = '1;
         mem_waddr = ref_row;
      end else begin
         if (acc_w) mem_we = NUM_BANKS'(1) << wbank;
         if (acc_r) mem_re = NUM_BANKS'(1) << rbank;
      end
      if (rst) begin
         mem_we = '0;
         mem_re = '0;
      end
      for (int b = 0; b < NUM_BANKS; b++) begin
         mem_wdata[b*WIDTH +: WIDTH] = (state_q == ST_REF_WR) ? bank_rd[b] : in;
      end
   end

   always_comb begin
      s1_d       = acc_r;
      bank_d     = rbank;
      byp_d      = acc_r && acc_w && (raddr == waddr);
      byp_data_d = in;
      rd_valid_d = s1_q;
      rd_d       = rd_q;
      if (s1_q) rd_d = byp_q ? byp_data_q : bank_rd[bank_q];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         ref_busy_q <= 1'b0;
         s1_q       <= 1'b0;
         bank_q     <= '0;
         byp_q      <= 1'b0;
         byp_data_q <= '0;
         rd_q       <= '0;
         rd_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         ref_busy_q <= ref_busy_d;
         s1_q       <= s1_d;
         bank_q     <= bank_d;
         byp_q      <= byp_d;
         byp_data_q <= byp_data_d;
         rd_q       <= rd_d;
         rd_valid_q <= rd_valid_d;
      end
   end

endmodule

// File: tb/tb_gc_dram_refresh_ctrl.sv
// tb/tb_gc_dram_refresh_ctrl.sv - randomized bench with array-content reference model for gc_dram_refresh_ctrl
module tb_gc_dram_refresh_ctrl;

   localparam int NB = 8;
   localparam int RW = 128;
   localparam int W  = 64;
   localparam int RI = 64;
   localparam int AW = 10;

   logic            clk, rst, we, re;
   logic [AW-1:0]   waddr, raddr;
   logic [W-1:0]    in;
   logic            ready, rd_valid, ref_busy;
   logic [W-1:0]    rd;
   logic [NB-1:0]   mem_we, mem_re;
   logic [6:0]      mem_waddr, mem_raddr;
   logic [NB*W-1:0] mem_wdata, mem_rd;

   gc_dram_refresh_ctrl dut (
      .clk(clk), .rst(rst), .we(we), .re(re), .waddr(waddr), .raddr(raddr), .in(in),
      .ready(ready), .rd(rd), .rd_valid(rd_valid), .ref_busy(ref_busy),
      .mem_we(mem_we), .mem_re(mem_re), .mem_waddr(mem_waddr), .mem_raddr(mem_raddr),
      .mem_wdata(mem_wdata), .mem_rd(mem_rd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_fail = 0;
   int t = 0;
   int n_acc = 0;
   int n_valid = 0;

   task automatic chk(input string nm, input logic [NB*W-1:0] act, input logic [NB*W-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, t);
      end
   endtask

   // Bank macros: synchronous read, read-before-write on the same edge.
   logic [W-1:0] bank_mem [NB][RW];
   logic [W-1:0] exp_arr  [NB][RW];

   initial begin
      mem_rd = '0;
      for (int b = 0; b < NB; b++) begin
         for (int r = 0; r < RW; r++) begin
            bank_mem[b][r] = {$urandom, $urandom};
            exp_arr[b][r]  = bank_mem[b][r];
         end
      end
   end

   always @(posedge clk) begin
      for (int b = 0; b < NB; b++) begin
         if (mem_re[b]) mem_rd[b*W +: W] <= bank_mem[b][mem_raddr];
         if (mem_we[b]) bank_mem[b][mem_waddr] <= mem_wdata[b*W +: W];
      end
   end

   typedef struct {
      int           due;
      logic [W-1:0] data;
   } rexp_t;
   rexp_t rq[$];

   // Reference: refresh k (k>=1) reads at cycle 64k and writes back at 64k+1, row (k-1) mod 128;
   // array contents change only through accepted user writes.
   always @(negedge clk) begin : cmp
      bit           rd_cyc, wr_cyc, ready_e, acc_w, acc_r, valid_e;
      int           row_e;
      logic [NB-1:0] we_e, re_e;
      logic [W-1:0] rdata_e;
      if (rst) begin
         chk("rst_mem_we", NB*W'(mem_we), '0);
         chk("rst_mem_re", NB*W'(mem_re), '0);
         chk("rst_ready", NB*W'(ready), '0);
         rq.delete();
         t = 0;
      end else begin
         rd_cyc  = (t >= RI) && (t % RI == 0);
         wr_cyc  = (t >= RI + 1) && (t % RI == 1);
         ready_e = !(rd_cyc || wr_cyc);
         acc_w   = we && ready_e;
         acc_r   = re && ready_e;
         chk("ready", NB*W'(ready), NB*W'(ready_e));
         chk("ref_busy", NB*W'(ref_busy), NB*W'(rd_cyc || wr_cyc));

         we_e = '0;
         re_e = '0;
         if (wr_cyc) begin
            we_e  = '1;
            row_e = (((t - 1) / RI) - 1) % RW;
            chk("ref_waddr", NB*W'(mem_waddr), NB*W'(row_e));
            for (int b = 0; b < NB; b++)
               chk("ref_wdata", NB*W'(mem_wdata[b*W +: W]), NB*W'(exp_arr[b][row_e]));
         end else if (acc_w) begin
            we_e = NB'(1) << waddr[9:7];
            chk("usr_waddr", NB*W'(mem_waddr), NB*W'(waddr[6:0]));
            chk("usr_wdata", mem_wdata, {NB{in}});
         end
         if (rd_cyc) begin
            re_e  = '1;
            row_e = ((t / RI) - 1) % RW;
            chk("ref_raddr", NB*W'(mem_raddr), NB*W'(row_e));
         end else if (acc_r) begin
            re_e = NB'(1) << raddr[9:7];
            chk("usr_raddr", NB*W'(mem_raddr), NB*W'(raddr[6:0]));
         end
         chk("mem_we", NB*W'(mem_we), NB*W'(we_e));
         chk("mem_re", NB*W'(mem_re), NB*W'(re_e));

         valid_e = (rq.size() > 0) && (rq[0].due == t);
         chk("rd_valid", NB*W'(rd_valid), NB*W'(valid_e));
         if (valid_e) begin
            chk("rd", NB*W'(rd), NB*W'(rq[0].data));
            void'(rq.pop_front());
         end
         if (rd_valid) n_valid++;

         if (acc_r) begin
            n_acc++;
            rdata_e = (acc_w && waddr == raddr) ? in : exp_arr[raddr[9:7]][raddr[6:0]];
            rq.push_back('{due: t + 2, data: rdata_e});
         end
         if (acc_w) exp_arr[waddr[9:7]][waddr[6:0]] = in;
         t++;
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cycle(input int target, input int budget);
      for (int i = 0; i < budget && t != target; i++) cyc();
      chk("reach_cycle", NB*W'(t), NB*W'(target));
   endtask

   initial begin
      int guard;
      rst = 1'b1; we = 1'b0; re = 1'b0; waddr = '0; raddr = '0; in = '0;
      repeat (3) cyc();
      rst = 1'b0;
      #2;
      chk("rst_ready1", NB*W'(ready), NB*W'(1'b1));
      chk("rst_rd", NB*W'(rd), '0);
      chk("rst_rd_valid", NB*W'(rd_valid), '0);
      chk("rst_ref_busy", NB*W'(ref_busy), '0);

      cyc(); we = 1'b1; waddr = 10'h085; in = 64'hDEADBEEF_00000001;
      #2 chk("wr085_mem_we", NB*W'(mem_we), NB*W'(8'b0000_0010));
      cyc(); we = 1'b0; re = 1'b1; raddr = 10'h085;
      cyc(); re = 1'b0;
      #2 chk("rd085_early", NB*W'(rd_valid), '0);
      cyc();
      #2 chk("rd085_valid", NB*W'(rd_valid), NB*W'(1'b1));
      chk("rd085_data", NB*W'(rd), NB*W'(64'hDEADBEEF_00000001));

      cyc(); we = 1'b1; re = 1'b1; waddr = 10'h3FF; raddr = 10'h3FF; in = 64'hA5A5A5A5_A5A5A5A5;
      cyc(); we = 1'b0; re = 1'b1;
      cyc(); re = 1'b0;
      #2 chk("byp_data", NB*W'(rd), NB*W'(64'hA5A5A5A5_A5A5A5A5));
      chk("byp_valid", NB*W'(rd_valid), NB*W'(1'b1));
      cyc();
      #2 chk("reread_data", NB*W'(rd), NB*W'(64'hA5A5A5A5_A5A5A5A5));

      wait_cycle(64, 200);
      #2 chk("ref0_mem_re", NB*W'(mem_re), NB*W'(8'hFF));
      chk("ref0_raddr", NB*W'(mem_raddr), '0);
      chk("ref0_ready", NB*W'(ready), '0);
      cyc();
      #2 chk("ref0_mem_we", NB*W'(mem_we), NB*W'(8'hFF));
      chk("ref0_waddr", NB*W'(mem_waddr), '0);
      chk("ref0_ready2", NB*W'(ready), '0);
      for (int b = 0; b < NB; b++)
         chk("ref0_wb", NB*W'(mem_wdata[b*W +: W]), NB*W'(mem_rd[b*W +: W]));
      cyc();
      #2 chk("ref0_done", NB*W'(ready), NB*W'(1'b1));

      guard = 0;
      while (t < 8260 && guard < 9000) begin
         guard++;
         cyc();
         we    = ($urandom_range(0, 2) == 0);
         waddr = ($urandom % 2 == 0) ? {3'($urandom), 7'($urandom_range(0, 3))} : 10'($urandom);
         in    = {$urandom, $urandom};
         re    = (t >= 300 && t <= 700) ? 1'b1 : 1'($urandom % 2);
         raddr = ($urandom % 4 == 0) ? waddr : {3'($urandom), 7'($urandom_range(0, 3))};
         #2;
         if (t == 128)  chk("ref1_raddr", NB*W'(mem_raddr), NB*W'(7'd1));
         if (t == 8192) chk("ref127_raddr", NB*W'(mem_raddr), NB*W'(7'd127));
         if (t == 8256) begin
            chk("wrap_raddr", NB*W'(mem_raddr), '0);
            chk("wrap_mem_re", NB*W'(mem_re), NB*W'(8'hFF));
         end
      end
      cyc(); we = 1'b0; re = 1'b0;
      repeat (3) cyc();
      chk("rd_count", NB*W'(n_valid), NB*W'(n_acc));

      re = 1'b1;
      guard = 0;
      while (!(t > 0 && t % RI == 0) && guard < 200) begin
         guard++;
         cyc();
         raddr = 10'($urandom);
      end
      chk("reach_ref_rd", NB*W'(t % RI), '0);
      rst = 1'b1;
      cyc(); rst = 1'b0; re = 1'b0;
      #2 chk("abort_mem_we", NB*W'(mem_we), '0);
      chk("abort_ref_busy", NB*W'(ref_busy), '0);
      chk("abort_rd_valid", NB*W'(rd_valid), '0);
      wait_cycle(64, 200);
      #2 chk("post_rst_mem_re", NB*W'(mem_re), NB*W'(8'hFF));
      chk("post_rst_raddr", NB*W'(mem_raddr), '0);
      repeat (4) cyc();

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/gc_dram_refresh_ctrl.md
# gc_dram_refresh_ctrl

Parametrised controller for a banked gain-cell DRAM array of NUM_BANKS identical single-port-pair macros (ROWS × WIDTH each). It sits between the user read/write port and the bank macros. It decodes a flat address into bank and row, returns read data with fixed latency and write-to-read bypass, and inserts periodic row refresh. Each refresh reads one row from every bank and writes it back, and the user port is stalled through a ready handshake while this happens.

## Interface
- NUM_BANKS, 8, number of macros; power of 2, ≥2
- ROWS, 128, rows per macro; power of 2
- WIDTH, 64, data width
- REF_INTERVAL, 64, cycles between refresh requests; ≥4
- Derived: BANK_W = clog2(NUM_BANKS), ROW_W = clog2(ROWS), ADDR_W = BANK_W+ROW_W

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- we  in  1  write request
- re  in  1  read request
- waddr  in  ADDR_W  write address, bank = [ADDR_W-1:ROW_W], row = [ROW_W-1:0]
- raddr  in  ADDR_W  read address, same split
- in  in  WIDTH  write data
- ready  out  1  requests are accepted only in cycles where ready=1
- rd  out  WIDTH  read data, registered
- rd_valid  out  1  rd holds data for a read accepted 2 cycles earlier
- ref_busy  out  1  refresh sequence in progress
- mem_we  out  NUM_BANKS  per-bank write enable
- mem_re  out  NUM_BANKS  per-bank read enable
- mem_waddr  out  ROW_W  shared row write address
- mem_raddr  out  ROW_W  shared row read address
- mem_wdata  out  NUM_BANKS×WIDTH  per-bank write data
- mem_rd  in  NUM_BANKS×WIDTH  per-bank read data; valid the cycle after mem_re (synchronous macro read)

## Operation
- FSM states: IDLE, REF_RD, REF_WR.
- Refresh timer:
  - Counts 0..REF_INTERVAL-1. On the terminal count it sets ref_pending and wraps to 0.
  - ref_row pointer wraps from ROWS-1 to 0.
  - One full-array refresh takes ROWS·REF_INTERVAL cycles.
- ready = (state==IDLE) && !ref_pending && !rst.
- IDLE with ready=1 (user traffic):
  - we=1: mem_we[bank(waddr)]=1, mem_waddr=row(waddr), mem_wdata[all]=in.
  - re=1: mem_re[bank(raddr)]=1, mem_raddr=row(raddr).
  - Outputs are combinational, so the macro samples them at the same edge.
- we/re while ready=0 are ignored, with no side effects. The requester holds the request until ready=1.
- IDLE with ref_pending=1 → REF_RD:
  - mem_re = all ones, mem_raddr = ref_row.
  - Clear ref_pending; assert ref_busy.
- REF_RD → REF_WR:
  - mem_we = all ones, mem_waddr = ref_row, mem_wdata[b] = mem_rd[b].
  - Then increment ref_row and return to IDLE. ref_busy deasserts in IDLE.
- Read return: register the bank index and a bypass flag at acceptance. One cycle later, register rd from mem_rd[bank_q], or from the bypass data.
- Bypass rule: if a read and a write are accepted in the same cycle with raddr==waddr, rd returns that cycle's write data.
- Reads and writes to different banks, or to different rows of the same bank, in the same cycle are both performed.

## Timing
- User write: accepted in cycle N, in the array after edge N.
- User read: accepted in cycle N, rd/rd_valid in cycle N+2. Fully pipelined: one read per ready cycle.
- Refresh occupies exactly 2 cycles with ready=0. A request is delayed at most 2 cycles, plus 1 if ref_pending rises in that cycle.
- The timer keeps running during refresh; REF_INTERVAL≥4 guarantees no pending overflow.
- Reset values: state IDLE, timer 0, ref_row 0, ref_pending 0, rd 0, rd_valid 0, ref_busy 0, read pipeline flushed.
- All mem_we/mem_re are forced to 0 while rst=1.
- Reset mid-refresh aborts the write-back. The row is not rewritten, and the sequence restarts from row 0.
- rd_valid is 0 in every cycle not corresponding to an accepted read, including reads in flight when reset is asserted.

## Structure
- Shared package gc_dram_pkg holds:
  - the FSM state enum
  - default parameter constants (8, 128, 64, 64)
  - address-split helper functions (bank_of, row_of)
- One sub-module, gc_dram_refresh_timer: interval counter, ref_pending set/clear, ref_row pointer.
- The controller and the bank macros are instantiated side by side in the top level.

## Test plan
All scenarios use default parameters.
- Write 0xDEADBEEF_00000001 to addr 0x085 (bank 1, row 5), then read 0x085 → mem_we=8'b0000_0010 at write, rd=0xDEADBEEF_00000001 with rd_valid exactly 2 cycles after read acceptance.
- Same-cycle we/re to addr 0x3FF, in=0xA5A5… → rd=0xA5A5… at N+2 (bypass); next read of 0x3FF also returns 0xA5A5….
- Idle 64 cycles after reset:
  - ready=0 for 2 cycles.
  - mem_re=8'hFF with raddr 0, then mem_we=8'hFF with waddr 0, each bank's mem_wdata equal to its prior mem_rd.
  - ref_row then 1.
- Back-to-back reads every cycle across a refresh → no request lost or duplicated; rd_valid count equals accepted-read count.
- Run 128·64 cycles → ref_row wraps 127→0.
- rst asserted during REF_RD → next cycle mem_we=0, ref_busy=0, rd_valid=0, first refresh after reset is row 0 at cycle 64.
